color_pal_loader: RTL and testbench

Writable 16-entry, 24-bit colour palette that replaces the fixed colour ROM in the HDMI output path. A byte-stream loader (valid/ready) receives a framed palette image into a shadow bank and commits it atomically to the active bank. The video side reads the active bank through an address/data port with ROM-compatible timing. Partially loaded palettes are never visible to the reader.

---
 rtl/color_pal_loader_if.sv | 34 +++
 rtl/color_pal_loader.sv | 242 ++++++++++++++++++++++++
 tb/tb_color_pal_loader.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/color_pal_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : color_pal_loader_if
//  Description : Byte-stream loader bus for the colour palette loader.
//                Carries the valid/ready byte handshake plus the synchronous
//                frame abort strobe.
//  Signals     : s_valid  - byte valid (master -> slave)
//                s_data   - byte data, 8 bits (master -> slave)
//                abort    - synchronous frame abort (master -> slave)
//                s_ready  - byte accepted at posedge when s_valid && s_ready
//                           (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface color_pal_loader_if;
   logic       s_valid;
   logic [7:0] s_data;
   logic       abort;
   logic       s_ready;

   modport master (
      output s_valid,
      output s_data,
      output abort,
      input  s_ready
   );

   modport slave (
      input  s_valid,
      input  s_data,
      input  abort,
      output s_ready
   );
endinterface
`default_nettype wire

// File: rtl/color_pal_loader.sv
`default_nettype none
// ============================================================================
//  Module      : color_pal_loader
//  Description : Writable 2**ADDR_WIDTH x DATA_WIDTH colour palette with a
//                double-buffered byte-stream loader. A framed palette image
//                (HEADER, payload MSB-first per entry, optional checksum) is
//                written into a shadow bank and copied atomically into the
//                active bank. The video side reads the active bank with a
//                registered, one-cycle-latency read port.
//  Option      : COLOR_PAL_CKSUM_EN - when defined, a trailing checksum byte
//                (8-bit sum of payload bytes) is required; a mismatch drops
//                the frame and pulses load_err. When undefined, frames are
//                header + payload only and load_err is tied low.
//  Ports       : clk       - clock
//                tb_rst    - asynchronous active-high reset
//                s_bus     - loader byte stream (s_valid/s_data/abort/s_ready)
//                rd_addr   - palette read index
//                rd_data   - registered palette entry (1-cycle latency)
//                busy      - frame in progress (state other than IDLE)
//                load_done - one-cycle pulse during the commit cycle
//                load_err  - one-cycle pulse after a bad checksum byte
//  Revision    : 1.0 - initial release
// ============================================================================
module color_pal_loader #(
   parameter int                    ADDR_WIDTH = 4,
   parameter int                    DATA_WIDTH = 24,
   parameter logic [7:0]            HEADER     = 8'hA5,
   parameter logic [DATA_WIDTH-1:0] INIT_COLOR = 24'hFFFFFF
) (
   input  logic                  clk,
   input  logic                  tb_rst,
   color_pal_loader_if.slave     s_bus,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  busy,
   output logic                  load_done,
   output logic                  load_err
);

   localparam int c_DEPTH = 2 ** ADDR_WIDTH;
   localparam int c_BPE   = DATA_WIDTH / 8;                  // bytes per entry
   localparam int c_BW    = (c_BPE > 1) ? $clog2(c_BPE) : 1;

   localparam logic [c_BW-1:0]       c_LAST_BYTE  = c_BW'(c_BPE - 1);
   localparam logic [ADDR_WIDTH-1:0] c_LAST_ENTRY = '1;

`ifdef COLOR_PAL_CKSUM_EN
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_CKSUM  = 2'd2,
      ST_COMMIT = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_COMMIT = 2'd3
   } state_t;
`endif

   state_t                  r_state;
   state_t                  w_next;

   logic                    w_ready;
   logic                    w_accept;
   logic                    w_hdr_hit;
   logic                    w_load_byte;
   logic                    w_last_payload;

   logic [c_BW-1:0]         r_bidx;      // byte position inside current entry
   logic [ADDR_WIDTH-1:0]   r_entry;     // entry index being assembled
   logic [DATA_WIDTH-1:0]   w_acc_next;  // entry value including current byte

   logic [DATA_WIDTH-1:0]   r_shadow [c_DEPTH];
   logic [DATA_WIDTH-1:0]   r_active [c_DEPTH];

   // Ready is gated by reset so the loader never advertises acceptance while
   // held in reset; abort and the commit cycle also block acceptance.
   assign w_ready        = ~tb_rst & ~s_bus.abort & (r_state != ST_COMMIT);
   assign w_accept       = s_bus.s_valid & w_ready;
   assign w_hdr_hit      = w_accept & (s_bus.s_data == HEADER);
   assign w_load_byte    = w_accept & (r_state == ST_LOAD);
   assign w_last_payload = (r_entry == c_LAST_ENTRY) && (r_bidx == c_LAST_BYTE);

   assign s_bus.s_ready  = w_ready;
   assign busy           = (r_state != ST_IDLE);
   assign load_done      = (r_state == ST_COMMIT);

   // -------------------------------------------------------------------------
   // Entry assembly: bytes arrive MSB first, so each accepted byte is shifted
   // in at the bottom of the partial entry.
   // -------------------------------------------------------------------------
   generate
      if (c_BPE > 1) begin : g_multi_byte
         logic [DATA_WIDTH-9:0] r_acc;

         assign w_acc_next = {r_acc, s_bus.s_data};

         always_ff @(posedge clk or posedge tb_rst) begin
            if (tb_rst) begin
               r_acc <= '0;
            end else if (w_load_byte) begin
               r_acc <= w_acc_next[DATA_WIDTH-9:0];
            end
         end
      end else begin : g_single_byte
         assign w_acc_next = s_bus.s_data;
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Checksum tracking (optional)
   // -------------------------------------------------------------------------
`ifdef COLOR_PAL_CKSUM_EN
   logic [7:0] r_sum;
   logic       w_err_set;
   logic       r_load_err;

   always_ff @(posedge clk or posedge tb_rst) begin
      if (tb_rst) begin
         r_sum      <= 8'd0;
         r_load_err <= 1'b0;
      end else begin
         r_load_err <= w_err_set;
         if ((r_state == ST_IDLE) && w_hdr_hit) begin
            r_sum <= 8'd0;
         end else if (w_load_byte) begin
            r_sum <= r_sum + s_bus.s_data;
         end
      end
   end

   assign load_err = r_load_err;
`else
   assign load_err = 1'b0;
`endif

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge tb_rst) begin
      if (tb_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // -------------------------------------------------------------------------
   // FSM: next state
   // -------------------------------------------------------------------------
   always_comb begin
      w_next = r_state;
`ifdef COLOR_PAL_CKSUM_EN
      w_err_set = 1'b0;
`endif
      case (r_state)
         ST_IDLE: begin
            if (w_hdr_hit) begin
               w_next = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (s_bus.abort) begin
               w_next = ST_IDLE;
            end else if (w_accept && w_last_payload) begin
`ifdef COLOR_PAL_CKSUM_EN
               w_next = ST_CKSUM;
`else
               w_next = ST_COMMIT;
`endif
            end
         end
`ifdef COLOR_PAL_CKSUM_EN
         ST_CKSUM: begin
            if (s_bus.abort) begin
               w_next = ST_IDLE;
            end else if (w_accept) begin
               if (s_bus.s_data == r_sum) begin
                  w_next = ST_COMMIT;
               end else begin
                  w_next    = ST_IDLE;
                  w_err_set = 1'b1;
               end
            end
         end
`endif
         ST_COMMIT: begin
            w_next = ST_IDLE;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Byte counters: header restarts them, payload bytes advance them.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge tb_rst) begin
      if (tb_rst) begin
         r_bidx  <= '0;
         r_entry <= '0;
      end else if ((r_state == ST_IDLE) && w_hdr_hit) begin
         r_bidx  <= '0;
         r_entry <= '0;
      end else if (w_load_byte) begin
         if (r_bidx == c_LAST_BYTE) begin
            r_bidx  <= '0;
            r_entry <= r_entry + 1'b1;
         end else begin
            r_bidx  <= r_bidx + 1'b1;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Palette banks and read port. The read uses the active bank value before
   // the commit edge, so a read sampled on that edge still returns the old
   // entry.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge tb_rst) begin
      if (tb_rst) begin
         for (int i = 0; i < c_DEPTH; i++) begin
            r_shadow[i] <= INIT_COLOR;
            r_active[i] <= INIT_COLOR;
         end
         rd_data <= INIT_COLOR;
      end else begin
         if (w_load_byte && (r_bidx == c_LAST_BYTE)) begin
            r_shadow[r_entry] <= w_acc_next;
         end
         if (r_state == ST_COMMIT) begin
            r_active <= r_shadow;
         end
         rd_data <= r_active[rd_addr];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_color_pal_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_color_pal_loader
//  Description : Self-checking bench for color_pal_loader. Palettes are kept
//                as plain arrays; a frame commits to the reference palette
//                only when it completes without abort and (with
//                COLOR_PAL_CKSUM_EN) with a correct checksum byte.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_color_pal_loader;

`ifdef COLOR_PAL_CKSUM_EN
   localparam bit c_CK = 1'b1;
`else
   localparam bit c_CK = 1'b0;
`endif

   typedef struct {
      logic [3:0]  addr;
      logic [23:0] exp;
   } rd_vec_t;

   logic        clk;
   logic        tb_rst;
   logic [3:0]  rd_addr;
   logic [23:0] rd_data;
   logic        busy;
   logic        load_done;
   logic        load_err;

   color_pal_loader_if bus ();

   color_pal_loader dut (
      .clk       (clk),
      .tb_rst    (tb_rst),
      .s_bus     (bus),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .busy      (busy),
      .load_done (load_done),
      .load_err  (load_err)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   int          mon_done = 0;
   int          mon_err  = 0;
   logic [23:0] ref_pal [16];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(negedge clk) begin
      if (load_done) mon_done <= mon_done + 1;
      if (load_err)  mon_err  <= mon_err + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [383:0] rand_pal();
      logic [383:0] p;
      for (int i = 0; i < 12; i++) p[i*32 +: 32] = $urandom;
      return p;
   endfunction

   task automatic commit_ref(input logic [383:0] pal);
      for (int i = 0; i < 16; i++) ref_pal[i] = pal[i*24 +: 24];
   endtask

   // Offer one byte (after an optional random gap) until it is accepted.
   task automatic put_byte(input logic [7:0] b, input int max_gap);
      int gap;
      int waited;
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (gap) begin
         @(negedge clk);
         bus.s_valid = 1'b0;
         bus.s_data  = 8'($urandom);
      end
      @(negedge clk);
      bus.s_valid = 1'b1;
      bus.s_data  = b;
      #1;
      waited = 0;
      while (!bus.s_ready && waited < 20) begin
         @(negedge clk);
         #1;
         waited++;
      end
      if (!bus.s_ready) chk("ready_timeout", 32'(bus.s_ready), 32'd1);
      else @(posedge clk);
   endtask

   task automatic do_abort();
      @(negedge clk);
      bus.s_valid = 1'b1;
      bus.s_data  = 8'hA5;
      bus.abort   = 1'b1;
      #1;
      chk("ready_low_during_abort", 32'(bus.s_ready), 32'd0);
      @(negedge clk);
      bus.abort   = 1'b0;
      bus.s_valid = 1'b0;
      chk("busy_after_abort", 32'(busy), 32'd0);
   endtask

   // abort_at = number of payload bytes accepted before abort (-1: none).
   task automatic send_frame(input logic [383:0] pal, input bit corrupt,
                             input int abort_at, input int max_gap);
      logic [7:0] sum;
      logic [7:0] bb;
      sum = 8'd0;
      put_byte(8'hA5, max_gap);
      for (int i = 0; i < 48; i++) begin
         if (i == abort_at) begin
            do_abort();
            return;
         end
         bb  = pal[(i/3)*24 + (2 - (i%3))*8 +: 8];
         sum = sum + bb;
         put_byte(bb, max_gap);
      end
`ifdef COLOR_PAL_CKSUM_EN
      if (abort_at == 48) begin
         do_abort();
         return;
      end
      put_byte(corrupt ? sum + 8'd1 : sum, max_gap);
`else
      if (corrupt) sum = 8'd0;
`endif
   endtask

   task automatic rd_chk(input logic [3:0] a, input string name);
      @(negedge clk);
      rd_addr = a;
      @(negedge clk);
      chk(name, 32'(rd_data), 32'(ref_pal[a]));
   endtask

   task automatic sweep(input string name);
      for (int a = 0; a < 16; a++) rd_chk(4'(a), name);
   endtask

   task automatic run_frame(input logic [383:0] pal, input bit corrupt,
                            input int abort_at, input int max_gap, input bit do_sweep);
      int  d0;
      int  e0;
      bit  ok;
      bit  err;
      d0 = mon_done;
      e0 = mon_err;
      send_frame(pal, corrupt, abort_at, max_gap);
      @(negedge clk);
      bus.s_valid = 1'b0;
      repeat (3) @(negedge clk);
      ok  = (abort_at < 0) && !(c_CK && corrupt);
      err = (abort_at < 0) && c_CK && corrupt;
      chk("load_done_pulses", 32'(mon_done - d0), 32'(ok));
      chk("load_err_pulses",  32'(mon_err - e0),  32'(err));
      chk("busy_when_idle",   32'(busy), 32'd0);
      if (ok) commit_ref(pal);
      if (do_sweep) sweep("rd_after_frame");
   endtask

   rd_vec_t      vec_reset [16];
   rd_vec_t      vec_a     [16];
   logic [383:0] pal_a;
   logic [383:0] pal_r;
   logic [7:0]   junk;
   int           d0;

   initial begin
      // Expected read tables.
      for (int i = 0; i < 16; i++) begin
         vec_reset[i] = '{addr: 4'(i), exp: 24'hFFFFFF};
         vec_a[i]     = '{addr: 4'(i), exp: {8'(i), 8'(8'h10 + i), 8'(8'h20 + i)}};
         pal_a[i*24 +: 24] = {8'(i), 8'(8'h10 + i), 8'(8'h20 + i)};
         ref_pal[i] = 24'hFFFFFF;
      end

      // ---------------- reset ----------------
      tb_rst      = 1'b1;
      bus.s_valid = 1'b0;
      bus.s_data  = 8'h00;
      bus.abort   = 1'b0;
      rd_addr     = 4'd0;
      repeat (2) @(negedge clk);
      chk("rst_s_ready",   32'(bus.s_ready), 32'd0);
      chk("rst_busy",      32'(busy),        32'd0);
      chk("rst_load_done", 32'(load_done),   32'd0);
      chk("rst_load_err",  32'(load_err),    32'd0);
      chk("rst_rd_data",   32'(rd_data),     32'hFFFFFF);
      tb_rst = 1'b0;
      #1;
      chk("s_ready_after_rst", 32'(bus.s_ready), 32'd1);

      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         rd_addr = vec_reset[k].addr;
         @(negedge clk);
         chk("rd_reset_table", 32'(rd_data), 32'(vec_reset[k].exp));
      end

      // ---------------- frame A, read of addr 3 held across commit -----------
      @(negedge clk);
      rd_addr = 4'd3;
      d0 = mon_done;
      send_frame(pal_a, 1'b0, -1, 0);
      @(negedge clk);
      bus.s_valid = 1'b0;
      chk("commit_load_done", 32'(load_done), 32'd1);
      chk("commit_busy",      32'(busy),      32'd1);
      chk("commit_s_ready",   32'(bus.s_ready), 32'd0);
      @(negedge clk);
      chk("rd_on_commit_edge", 32'(rd_data), 32'hFFFFFF);
      @(negedge clk);
      chk("rd_after_commit",   32'(rd_data), 32'h031323);
      repeat (2) @(negedge clk);
      chk("frame_a_done_once", 32'(mon_done - d0), 32'd1);
      chk("frame_a_busy",      32'(busy), 32'd0);
      commit_ref(pal_a);

      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         rd_addr = vec_a[k].addr;
         @(negedge clk);
         chk("rd_frame_a_table", 32'(rd_data), 32'(vec_a[k].exp));
      end
      rd_chk(4'd5, "rd_addr5");
      chk("addr5_value", 32'(rd_data), 32'h051525);

      // ---------------- bad checksum: same frame, then a different palette ---
      run_frame(pal_a, 1'b1, -1, 0, 1'b0);
      run_frame(rand_pal(), 1'b1, -1, 0, 1'b1);

      // ---------------- leading junk then gapped frame ----------------
      put_byte(8'h00, 0);
      put_byte(8'h3C, 0);
      put_byte(8'hFF, 0);
      run_frame(rand_pal(), 1'b0, -1, 3, 1'b1);

      // ---------------- abort after 20 payload bytes, then full frame --------
      run_frame(rand_pal(), 1'b0, 20, 1, 1'b0);
      run_frame(rand_pal(), 1'b0, -1, 0, 1'b1);

      // ---------------- randomized frames ----------------
      for (int it = 0; it < 8; it++) begin
         int ab;
         int nj;
         nj = int'($urandom_range(2, 0));
         for (int j = 0; j < nj; j++) begin
            junk = 8'($urandom);
            if (junk == 8'hA5) junk = 8'h5A;
            put_byte(junk, 1);
         end
         ab = ($urandom_range(2, 0) == 0) ? int'($urandom_range(c_CK ? 48 : 47, 0)) : -1;
         run_frame(rand_pal(), 1'($urandom_range(1, 0)), ab,
                   int'($urandom_range(2, 0)), 1'b1);
      end

      // ---------------- asynchronous reset mid-frame ----------------
      put_byte(8'hA5, 0);
      for (int i = 0; i < 10; i++) put_byte(8'($urandom), 0);
      #2;
      tb_rst = 1'b1;
      #1;
      chk("midrst_busy",    32'(busy),        32'd0);
      chk("midrst_rd_data", 32'(rd_data),     32'hFFFFFF);
      chk("midrst_s_ready", 32'(bus.s_ready), 32'd0);
      for (int i = 0; i < 16; i++) ref_pal[i] = 24'hFFFFFF;
      @(negedge clk);
      bus.s_valid = 1'b0;
      tb_rst      = 1'b0;
      sweep("rd_after_midrst");
      run_frame(pal_a, 1'b0, -1, 0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
